soc_mem_router: RTL and testbench

//  Consumes the CPU wrapper's mem_cmd_*/mem_rsp_* port and routes each access to on-chip RAM or a peripheral bus.

---
 rtl/soc_mem_router_pkg.sv | 35 +++
 rtl/soc_mem_periph_port.sv | 81 ++++++++
 rtl/soc_mem_router.sv | 179 +++++++++++++++++
 tb/tb_soc_mem_router.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_router_pkg.sv
// Shared types and defaults for the soc_mem_router slice: FSM state encoding,
// region defaults and the address-region decode helper.
package soc_mem_router_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAM_RD  = 3'd1,
      ST_PER_CMD = 3'd2,
      ST_PER_RSP = 3'd3,
      ST_ERR_RD  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      RGN_RAM    = 2'd0,
      RGN_PERIPH = 2'd1,
      RGN_NONE   = 2'd2
   } region_e;

   localparam logic [3:0]  RAM_REGION_DEF    = 4'h0;
   localparam logic [3:0]  PERIPH_REGION_DEF = 4'hF;
   localparam logic [31:0] UNMAPPED_DATA_DEF = 32'hDEAD_BEEF;

   function automatic region_e decode_region(input logic [3:0] rgn,
                                             input logic [3:0] ram_rgn,
                                             input logic [3:0] per_rgn);
      if (rgn == ram_rgn) begin
         return RGN_RAM;
      end else if (rgn == per_rgn) begin
         return RGN_PERIPH;
      end else begin
         return RGN_NONE;
      end
   endfunction

endpackage

// File: rtl/soc_mem_periph_port.sv
// Peripheral-bus side of soc_mem_router: latched command, handshake events and,
// when MEM_TIMEOUT_EN is defined, the stall timeout counter.
module soc_mem_periph_port
   import soc_mem_router_pkg::*;
#(
   parameter int PERIPH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        start,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_be,
   input  logic        in_cmd,
   input  logic        in_rsp,
   output logic        periph_cmd_valid,
   input  logic        periph_cmd_ready,
   output logic        periph_cmd_wr,
   output logic [31:0] periph_cmd_addr,
   output logic [31:0] periph_cmd_wdata,
   output logic [3:0]  periph_cmd_be,
   input  logic        periph_rsp_valid,
   output logic        cmd_done,
   output logic        rsp_done,
   output logic        timeout
);

   localparam logic [15:0] TO_LAST = 16'(PERIPH_TIMEOUT - 1);

   logic        wr_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  be_r;

   // Capture the command so it stays stable while the peripheral stalls
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_r    <= 1'b0;
         addr_r  <= 32'd0;
         wdata_r <= 32'd0;
         be_r    <= 4'd0;
      end else if (start) begin
         wr_r    <= cmd_wr;
         addr_r  <= cmd_addr;
         wdata_r <= cmd_wdata;
         be_r    <= cmd_be;
      end
   end

   assign periph_cmd_valid = in_cmd;
   assign periph_cmd_wr    = wr_r;
   assign periph_cmd_addr  = addr_r;
   assign periph_cmd_wdata = wdata_r;
   assign periph_cmd_be    = be_r;
   assign cmd_done         = in_cmd && periph_cmd_ready;
   assign rsp_done         = in_rsp && periph_rsp_valid;

`ifdef MEM_TIMEOUT_EN
   logic [15:0] cnt_r;

   // Cycles spent in PER_CMD+PER_RSP for the current access
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt_r <= 16'd0;
      end else if (start) begin
         cnt_r <= 16'd0;
      end else if (in_cmd || in_rsp) begin
         cnt_r <= cnt_r + 16'd1;
      end
   end

   // A handshake landing on the last allowed cycle still wins over the timeout
   assign timeout = (in_cmd || in_rsp) && (cnt_r >= TO_LAST) && !cmd_done && !rsp_done;
`else
   logic unused_s;
   assign unused_s = ^TO_LAST;
   assign timeout  = 1'b0;
`endif

endmodule

// File: rtl/soc_mem_router.sv
// Routes CPU mem_cmd/mem_rsp accesses to on-chip RAM or the peripheral bus.
// Optional peripheral stall timeout is enabled by defining MEM_TIMEOUT_EN.
module soc_mem_router
   import soc_mem_router_pkg::*;
#(
   parameter int          RAM_AW         = 12,
   parameter logic [3:0]  RAM_REGION     = RAM_REGION_DEF,
   parameter logic [3:0]  PERIPH_REGION  = PERIPH_REGION_DEF,
   parameter logic [31:0] UNMAPPED_DATA  = UNMAPPED_DATA_DEF,
   parameter int          PERIPH_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              mem_cmd_valid,
   output logic              mem_cmd_ready,
   input  logic              mem_cmd_instr,
   input  logic              mem_cmd_wr,
   input  logic [31:0]       mem_cmd_addr,
   input  logic [31:0]       mem_cmd_wdata,
   input  logic [3:0]        mem_cmd_be,
   output logic              mem_rsp_ready,
   output logic [31:0]       mem_rsp_rdata,
   output logic              ram_req,
   output logic              ram_wr,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_be,
   input  logic [31:0]       ram_rdata,
   output logic              periph_cmd_valid,
   input  logic              periph_cmd_ready,
   output logic              periph_cmd_wr,
   output logic [31:0]       periph_cmd_addr,
   output logic [31:0]       periph_cmd_wdata,
   output logic [3:0]        periph_cmd_be,
   input  logic              periph_rsp_valid,
   input  logic [31:0]       periph_rsp_rdata,
   output logic              bus_err
);

   state_e      state_r;
   state_e      state_nxt_s;
   region_e     region_s;
   logic        run_r;
   logic        accept_s;
   logic        per_start_s;
   logic        rsp_set_s;
   logic [31:0] rsp_data_s;
   logic        err_set_s;
   logic        rsp_ready_r;
   logic [31:0] rdata_r;
   logic        bus_err_r;
   logic        cmd_done_s;
   logic        rsp_done_s;
   logic        timeout_s;
   logic        unused_s;

   assign unused_s = mem_cmd_instr;

   assign region_s      = decode_region(mem_cmd_addr[31:28], RAM_REGION, PERIPH_REGION);
   // run_r keeps the port closed until the first clock after reset release
   assign mem_cmd_ready = run_r && (state_r == ST_IDLE);
   assign accept_s      = mem_cmd_valid && mem_cmd_ready;
   assign per_start_s   = accept_s && (region_s == RGN_PERIPH);

   assign ram_req   = accept_s && (region_s == RGN_RAM);
   assign ram_wr    = ram_req && mem_cmd_wr;
   assign ram_addr  = mem_cmd_addr[RAM_AW+1:2];
   assign ram_wdata = mem_cmd_wdata;
   assign ram_be    = mem_cmd_be;

   soc_mem_periph_port #(
      .PERIPH_TIMEOUT (PERIPH_TIMEOUT)
   ) u_periph (
      .clk              (clk),
      .reset_           (reset_),
      .start            (per_start_s),
      .cmd_wr           (mem_cmd_wr),
      .cmd_addr         (mem_cmd_addr),
      .cmd_wdata        (mem_cmd_wdata),
      .cmd_be           (mem_cmd_be),
      .in_cmd           (state_r == ST_PER_CMD),
      .in_rsp           (state_r == ST_PER_RSP),
      .periph_cmd_valid (periph_cmd_valid),
      .periph_cmd_ready (periph_cmd_ready),
      .periph_cmd_wr    (periph_cmd_wr),
      .periph_cmd_addr  (periph_cmd_addr),
      .periph_cmd_wdata (periph_cmd_wdata),
      .periph_cmd_be    (periph_cmd_be),
      .periph_rsp_valid (periph_rsp_valid),
      .cmd_done         (cmd_done_s),
      .rsp_done         (rsp_done_s),
      .timeout          (timeout_s)
   );

   // Next-state and response/error pulse selection
   always_comb begin
      state_nxt_s = state_r;
      rsp_set_s   = 1'b0;
      rsp_data_s  = 32'd0;
      err_set_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               case (region_s)
                  RGN_RAM:    state_nxt_s = mem_cmd_wr ? ST_IDLE : ST_RAM_RD;
                  RGN_PERIPH: state_nxt_s = ST_PER_CMD;
                  default: begin
                     err_set_s   = 1'b1;
                     state_nxt_s = mem_cmd_wr ? ST_IDLE : ST_ERR_RD;
                  end
               endcase
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RAM_RD: begin
            rsp_set_s   = 1'b1;
            rsp_data_s  = ram_rdata;
            state_nxt_s = ST_IDLE;
         end
         ST_ERR_RD: begin
            rsp_set_s   = 1'b1;
            rsp_data_s  = UNMAPPED_DATA;
            state_nxt_s = ST_IDLE;
         end
         ST_PER_CMD: begin
            if (cmd_done_s) begin
               state_nxt_s = periph_cmd_wr ? ST_IDLE : ST_PER_RSP;
            end else if (timeout_s) begin
               err_set_s   = 1'b1;
               rsp_set_s   = !periph_cmd_wr;
               rsp_data_s  = UNMAPPED_DATA;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_PER_CMD;
            end
         end
         ST_PER_RSP: begin
            if (rsp_done_s) begin
               rsp_set_s   = 1'b1;
               rsp_data_s  = periph_rsp_rdata;
               state_nxt_s = ST_IDLE;
            end else if (timeout_s) begin
               err_set_s   = 1'b1;
               rsp_set_s   = 1'b1;
               rsp_data_s  = UNMAPPED_DATA;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_PER_RSP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register plus registered response and error pulses
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_r     <= ST_IDLE;
         run_r       <= 1'b0;
         rsp_ready_r <= 1'b0;
         rdata_r     <= 32'd0;
         bus_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         run_r       <= 1'b1;
         rsp_ready_r <= rsp_set_s;
         bus_err_r   <= err_set_s;
         if (rsp_set_s) begin
            rdata_r <= rsp_data_s;
         end
      end
   end

   assign mem_rsp_ready = rsp_ready_r;
   assign mem_rsp_rdata = rdata_r;
   assign bus_err       = bus_err_r;

endmodule

// File: tb/tb_soc_mem_router.sv
// Self-checking bench for soc_mem_router: table-driven RAM/unmapped accesses
// plus hand-written peripheral, timeout and reset sequences.
module tb_soc_mem_router;

   localparam int RAM_AW = 6;

   logic              clk = 1'b0;
   logic              reset_;
   logic              mem_cmd_valid, mem_cmd_ready, mem_cmd_instr, mem_cmd_wr;
   logic [31:0]       mem_cmd_addr, mem_cmd_wdata;
   logic [3:0]        mem_cmd_be;
   logic              mem_rsp_ready;
   logic [31:0]       mem_rsp_rdata;
   logic              ram_req, ram_wr;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;
   logic [3:0]        ram_be;
   logic              periph_cmd_valid, periph_cmd_ready, periph_cmd_wr;
   logic [31:0]       periph_cmd_addr, periph_cmd_wdata;
   logic [3:0]        periph_cmd_be;
   logic              periph_rsp_valid;
   logic [31:0]       periph_rsp_rdata;
   logic              bus_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   soc_mem_router #(.RAM_AW(RAM_AW), .PERIPH_TIMEOUT(8)) dut (
      .clk(clk), .reset_(reset_),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_instr(mem_cmd_instr), .mem_cmd_wr(mem_cmd_wr),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
      .mem_cmd_be(mem_cmd_be), .mem_rsp_ready(mem_rsp_ready),
      .mem_rsp_rdata(mem_rsp_rdata), .ram_req(ram_req), .ram_wr(ram_wr),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
      .ram_rdata(ram_rdata), .periph_cmd_valid(periph_cmd_valid),
      .periph_cmd_ready(periph_cmd_ready), .periph_cmd_wr(periph_cmd_wr),
      .periph_cmd_addr(periph_cmd_addr), .periph_cmd_wdata(periph_cmd_wdata),
      .periph_cmd_be(periph_cmd_be), .periph_rsp_valid(periph_rsp_valid),
      .periph_rsp_rdata(periph_rsp_rdata), .bus_err(bus_err)
   );

   // Behavioural RAM: byte-enabled writes, one-cycle registered reads
   logic [31:0] ram_mem [0:(1<<RAM_AW)-1];
   always @(posedge clk) begin
      if (ram_req && ram_wr) begin
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      if (ram_req && !ram_wr) ram_rdata <= ram_mem[ram_addr];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access starting in an idle cycle; observes cycles 1..5 after the command
   task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output int rsp_cnt, output int rsp_cyc,
                             output logic [31:0] rdata, output int err_cnt, output int per_cnt,
                             output logic ram_seen, output logic rdy_seen);
      rsp_cnt = 0; rsp_cyc = 0; rdata = 32'd0; err_cnt = 0; per_cnt = 0;
      rdy_seen      = mem_cmd_ready;
      mem_cmd_valid = 1'b1;
      mem_cmd_wr    = wr;
      mem_cmd_addr  = addr;
      mem_cmd_wdata = wdata;
      mem_cmd_be    = be;
      #1 ram_seen = ram_req;
      @(posedge clk);
      #1 mem_cmd_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (mem_rsp_ready) begin
            rsp_cnt++;
            if (rsp_cnt == 1) begin
               rsp_cyc = c;
               rdata   = mem_rsp_rdata;
            end
         end
         if (bus_err) err_cnt++;
         if (periph_cmd_valid) per_cnt++;
         tick();
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_ram;
   } vec_t;

   vec_t        vecs [10];
   int          rsp_cnt, rsp_cyc, err_cnt, per_cnt, rdy_hi, pv_cnt, err_cyc;
   logic [31:0] rdata;
   logic        ram_seen, rdy_seen;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'h1234_5678, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 32'h0000_0020, 32'hAAAA_BBBB, 4'h3, 32'h0, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'hFFFF_BBBB, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 32'h0000_0113, 32'h0,         4'hF, 32'h1234_5678, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 32'h8000_0000, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 32'h8000_0000, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 32'h0ABC_0024, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 32'h0000_0024, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0, 1'b1};

      reset_ = 1'b0;
      mem_cmd_valid = 1'b1; mem_cmd_instr = 1'b0; mem_cmd_wr = 1'b0;
      mem_cmd_addr = 32'h0000_0010; mem_cmd_wdata = 32'd0; mem_cmd_be = 4'hF;
      periph_cmd_ready = 1'b0; periph_rsp_valid = 1'b0; periph_rsp_rdata = 32'd0;
      repeat (3) tick();
      check("rst_cmd_ready", {31'd0, mem_cmd_ready}, 32'd0);
      check("rst_ram_req", {31'd0, ram_req}, 32'd0);
      check("rst_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
      check("rst_pcmd_valid", {31'd0, periph_cmd_valid}, 32'd0);
      check("rst_bus_err", {31'd0, bus_err}, 32'd0);
      check("rst_rdata", mem_rsp_rdata, 32'd0);
      mem_cmd_valid = 1'b0;
      reset_ = 1'b1;
      tick();
      check("post_rst_cmd_ready", {31'd0, mem_cmd_ready}, 32'd1);

      for (int i = 0; i < 10; i++) begin
         run_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                    rsp_cnt, rsp_cyc, rdata, err_cnt, per_cnt, ram_seen, rdy_seen);
         check($sformatf("v%0d_cmd_ready", i), {31'd0, rdy_seen}, 32'd1);
         check($sformatf("v%0d_ram_req", i), {31'd0, ram_seen}, {31'd0, vecs[i].exp_ram});
         check($sformatf("v%0d_rsp_cnt", i), rsp_cnt, vecs[i].wr ? 32'd0 : 32'd1);
         check($sformatf("v%0d_err_cnt", i), err_cnt, {31'd0, vecs[i].exp_err});
         check($sformatf("v%0d_periph", i), per_cnt, 32'd0);
         if (!vecs[i].wr) begin
            check($sformatf("v%0d_rsp_cyc", i), rsp_cyc, 32'd2);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
         end
      end

      // Back-to-back RAM writes, one per cycle
      for (int i = 0; i < 3; i++) begin
         mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b1; mem_cmd_be = 4'hF;
         mem_cmd_addr  = 32'h0000_0030 + 32'(4*i);
         mem_cmd_wdata = 32'h0100_0000 + 32'(i);
         #1;
         check($sformatf("b2b%0d_ready", i), {31'd0, mem_cmd_ready}, 32'd1);
         check($sformatf("b2b%0d_ram_req", i), {31'd0, ram_req}, 32'd1);
         @(posedge clk);
         #1;
      end
      mem_cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_access(1'b0, 32'h0000_0030 + 32'(4*i), 32'd0, 4'hF,
                    rsp_cnt, rsp_cyc, rdata, err_cnt, per_cnt, ram_seen, rdy_seen);
         check($sformatf("b2b%0d_rdata", i), rdata, 32'h0100_0000 + 32'(i));
      end

      // Peripheral read: cmd_ready low 3 cycles, response 5 cycles later, stray rsp_valid early
      mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b0; mem_cmd_addr = 32'hF000_0004;
      #1 check("prd_ram_req", {31'd0, ram_req}, 32'd0);
      @(posedge clk);
      #1 mem_cmd_valid = 1'b0;
      rsp_cnt = 0; rsp_cyc = 0; rdy_hi = 0; pv_cnt = 0; rdata = 32'd0;
      for (int c = 1; c <= 13; c++) begin
         periph_cmd_ready = (c == 4);
         periph_rsp_valid = (c == 1) || (c == 10);
         periph_rsp_rdata = (c == 10) ? 32'h5A5A_1234 : 32'h0BAD_0BAD;
         #1;
         if (c == 1) begin
            check("prd_addr", periph_cmd_addr, 32'hF000_0004);
            check("prd_wr", {31'd0, periph_cmd_wr}, 32'd0);
         end
         if (mem_rsp_ready) begin
            rsp_cnt++;
            rsp_cyc = c;
            rdata   = mem_rsp_rdata;
         end
         if (c <= 10 && mem_cmd_ready) rdy_hi++;
         if (periph_cmd_valid) pv_cnt++;
         tick();
      end
      periph_cmd_ready = 1'b0; periph_rsp_valid = 1'b0;
      check("prd_rsp_cnt", rsp_cnt, 32'd1);
      check("prd_rsp_cyc", rsp_cyc, 32'd11);
      check("prd_rdata", rdata, 32'h5A5A_1234);
      check("prd_cmd_ready_low", rdy_hi, 32'd0);
      check("prd_pcmd_cycles", pv_cnt, 32'd4);

      // Posted peripheral write
      mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b1; mem_cmd_addr = 32'hF000_0100;
      mem_cmd_wdata = 32'h1122_3344; mem_cmd_be = 4'hC;
      tick();
      mem_cmd_valid = 1'b0; periph_cmd_ready = 1'b1;
      #1;
      check("pwr_valid", {31'd0, periph_cmd_valid}, 32'd1);
      check("pwr_wr", {31'd0, periph_cmd_wr}, 32'd1);
      check("pwr_wdata", periph_cmd_wdata, 32'h1122_3344);
      check("pwr_be", {28'd0, periph_cmd_be}, 32'hC);
      tick();
      periph_cmd_ready = 1'b0;
      #1;
      check("pwr_done_valid", {31'd0, periph_cmd_valid}, 32'd0);
      check("pwr_done_ready", {31'd0, mem_cmd_ready}, 32'd1);
      check("pwr_no_rsp", {31'd0, mem_rsp_ready}, 32'd0);

      // Peripheral that never accepts a read
      mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b0; mem_cmd_addr = 32'hF000_0008;
      tick();
      mem_cmd_valid = 1'b0;
      rsp_cnt = 0; rsp_cyc = 0; err_cnt = 0; err_cyc = 0; pv_cnt = 0; rdata = 32'd0;
      for (int c = 1; c <= 12; c++) begin
         if (mem_rsp_ready) begin
            rsp_cnt++;
            rsp_cyc = c;
            rdata   = mem_rsp_rdata;
         end
         if (bus_err) begin
            err_cnt++;
            err_cyc = c;
         end
         if (periph_cmd_valid) pv_cnt++;
         tick();
      end
`ifdef MEM_TIMEOUT_EN
      // Eight cycles in PER_CMD (1..8), timeout pulses visible in cycle 9
      check("to_rsp_cnt", rsp_cnt, 32'd1);
      check("to_rsp_cyc", rsp_cyc, 32'd9);
      check("to_rdata", rdata, 32'hDEAD_BEEF);
      check("to_err_cnt", err_cnt, 32'd1);
      check("to_err_cyc", err_cyc, 32'd9);
      check("to_pcmd_cycles", pv_cnt, 32'd8);
      check("to_idle", {31'd0, mem_cmd_ready}, 32'd1);
`else
      check("stall_rsp_cnt", rsp_cnt, 32'd0);
      check("stall_err_cnt", err_cnt, 32'd0);
      check("stall_pcmd_cycles", pv_cnt, 32'd12);
      check("stall_cmd_ready", {31'd0, mem_cmd_ready}, 32'd0);
      periph_cmd_ready = 1'b1;
      tick();
      periph_cmd_ready = 1'b0; periph_rsp_valid = 1'b1; periph_rsp_rdata = 32'h0F0F_F0F0;
      tick();
      periph_rsp_valid = 1'b0;
      check("stall_rsp", {31'd0, mem_rsp_ready}, 32'd1);
      check("stall_rdata", mem_rsp_rdata, 32'h0F0F_F0F0);
      tick();
`endif

      // Asynchronous reset while waiting in PER_RSP
      mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b0; mem_cmd_addr = 32'hF000_000C;
      tick();
      mem_cmd_valid = 1'b0; periph_cmd_ready = 1'b1;
      tick();
      periph_cmd_ready = 1'b0;
      #2 reset_ = 1'b0;
      #1;
      check("arst_pcmd_valid", {31'd0, periph_cmd_valid}, 32'd0);
      check("arst_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
      check("arst_cmd_ready", {31'd0, mem_cmd_ready}, 32'd0);
      check("arst_rdata", mem_rsp_rdata, 32'd0);
      periph_rsp_valid = 1'b1; periph_rsp_rdata = 32'h7777_7777;
      tick();
      reset_ = 1'b1;
      rsp_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         if (mem_rsp_ready) rsp_cnt++;
         tick();
      end
      periph_rsp_valid = 1'b0;
      check("arst_no_rsp", rsp_cnt, 32'd0);
      run_access(1'b0, 32'h0000_0010, 32'd0, 4'hF,
                 rsp_cnt, rsp_cyc, rdata, err_cnt, per_cnt, ram_seen, rdy_seen);
      check("arst_ram_ready", {31'd0, rdy_seen}, 32'd1);
      check("arst_ram_cyc", rsp_cyc, 32'd2);
      check("arst_ram_rdata", rdata, 32'h1234_5678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
